// File: rtl/avr_fb_writer.sv
// avr_fb_writer: AVR parallel-port byte stream -> word FIFO -> framebuffer SRAM write port.
// Define AVR_FB_READBACK_EN to enable the status readback byte on the AVR bus.
module avr_fb_writer #(
   parameter int AW          = 18,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    avr_din,
   input  logic          avr_ce_n,
   input  logic          avr_re_n,
   input  logic          avr_we_n,
   input  logic          avr_ae_p,
   input  logic          avr_de_p,
   output logic [7:0]    avr_dout,
   output logic          avr_doe,
   output logic          avr_r_n_b,
   output logic          wr_req,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   input  logic          wr_ack,
   output logic          ovf
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = 13;
   // idle bus: strobes and chip enable high, phase selects low
   localparam logic [SW-1:0] SYNC_RST = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
   logic [SW-1:0] sync_out;
   logic [7:0]    din_s;
   logic          ce_s, re_s, we_s, ae_s, de_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      end else begin
         sync_q[0] <= {avr_din, avr_ce_n, avr_re_n, avr_we_n, avr_ae_p, avr_de_p};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign din_s    = sync_out[12:5];
   assign ce_s     = sync_out[4];
   assign re_s     = sync_out[3];
   assign we_s     = sync_out[2];
   assign ae_s     = sync_out[1];
   assign de_s     = sync_out[0];

   logic we_prev, ce_prev;
   logic wr_evt, ce_rise, addr_evt, data_evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_prev <= 1'b1;
         ce_prev <= 1'b1;
      end else begin
         we_prev <= we_s;
         ce_prev <= ce_s;
      end
   end

   assign wr_evt   = we_s & ~we_prev & ~ce_s;
   assign ce_rise  = ce_s & ~ce_prev;
   assign addr_evt = wr_evt & ae_s;
   assign data_evt = wr_evt & ~ae_s & de_s;

   logic [AW+15:0] mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           fifo_full, fifo_empty, push, pop, load;
   logic [AW-1:0]  addr_q;
   logic [1:0]     aptr;
   logic           half;
   logic [7:0]     lo_q;

   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = data_evt & half & ~fifo_full;
   assign pop        = wr_req & wr_ack;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {addr_q, din_s, lo_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         avr_r_n_b <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         avr_r_n_b <= (count < CW'(FIFO_DEPTH - 1));
      end
   end

   // top address byte only carries bits AW-1:16 (AW is expected in 17..24)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         aptr   <= 2'd0;
         half   <= 1'b0;
         lo_q   <= 8'h00;
         ovf    <= 1'b0;
      end else begin
         if (ce_rise) begin
            aptr <= 2'd0;
            half <= 1'b0;
         end
         if (addr_evt) begin
            case (aptr)
               2'd0:    addr_q[7:0]   <= din_s;
               2'd1:    addr_q[15:8]  <= din_s;
               default: addr_q[AW-1:16] <= din_s[AW-17:0];
            endcase
            if (aptr != 2'd2) aptr <= aptr + 2'd1;
            half <= 1'b0;
            ovf  <= 1'b0;
         end
         if (data_evt) begin
            if (!half) begin
               lo_q <= din_s;
               half <= 1'b1;
            end else begin
               half <= 1'b0;
               if (fifo_full) ovf <= 1'b1;
               else           addr_q <= addr_q + AW'(1);
            end
         end
      end
   end

   // Drain FSM
   // state  | meaning
   // S_IDLE | no request outstanding; loads FIFO head when non-empty
   // S_REQ  | wr_req high, bus held until wr_ack
   typedef enum logic {S_IDLE, S_REQ} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         S_IDLE: if (!fifo_empty) begin
            load      = 1'b1;
            state_nxt = S_REQ;
         end
         S_REQ:   if (wr_ack) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign wr_req = (state == S_REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr <= '0;
         wr_data <= 16'h0000;
      end else if (load) begin
         {wr_addr, wr_data} <= mem[rd_ptr];
      end
   end

`ifdef AVR_FB_READBACK_EN
   logic       rd_cond;
   logic [3:0] cnt4;

   assign rd_cond = ~ce_s & ~re_s & ae_s;
   assign cnt4    = (32'(count) > 32'd15) ? 4'hF : 4'(count);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avr_doe  <= 1'b0;
         avr_dout <= 8'h00;
      end else begin
         avr_doe  <= rd_cond;
         avr_dout <= rd_cond ? {ovf, ~avr_r_n_b, fifo_empty, 1'b0, cnt4} : 8'h00;
      end
   end
`else
   logic unused_re;
   assign unused_re = re_s;
   assign avr_doe   = 1'b0;
   assign avr_dout  = 8'h00;
`endif

endmodule

// File: tb/tb_avr_fb_writer.sv
// Randomised bench for avr_fb_writer: a transaction-level model predicts every SRAM write,
// the ready/overflow flags and the readback byte; one negedge process checks the DUT.
`timescale 1ns/1ps
module tb_avr_fb_writer;
   localparam int AW    = 18;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    avr_din;
   logic          avr_ce_n, avr_re_n, avr_we_n, avr_ae_p, avr_de_p;
   logic [7:0]    avr_dout;
   logic          avr_doe, avr_r_n_b, wr_req, wr_ack, ovf;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;

   avr_fb_writer #(.AW(AW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .avr_din(avr_din), .avr_ce_n(avr_ce_n), .avr_re_n(avr_re_n),
      .avr_we_n(avr_we_n), .avr_ae_p(avr_ae_p), .avr_de_p(avr_de_p), .avr_dout(avr_dout),
      .avr_doe(avr_doe), .avr_r_n_b(avr_r_n_b), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .ovf(ovf));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // model: address register, byte pointers, sticky overflow, queue of expected writes
   logic [AW+15:0] exp_q[$];
   logic [AW+15:0] obs_log[$];
   logic [AW-1:0]  m_addr;
   int             m_aptr;
   bit             m_half;
   logic [7:0]     m_lo;
   bit             m_ovf;

   task automatic model_reset();
      m_addr = '0; m_aptr = 0; m_half = 0; m_lo = 8'h00; m_ovf = 0;
      exp_q.delete();
   endtask

   task automatic model_write(input bit ae, input bit de, input logic [7:0] b);
      int a;
      if (ae) begin
         a = int'(m_addr);
         a = (a & ~(255 << (8 * m_aptr))) | (int'(b) << (8 * m_aptr));
         m_addr = AW'(a & ((1 << AW) - 1));
         m_aptr = (m_aptr < 2) ? m_aptr + 1 : 2;
         m_half = 0;
         m_ovf  = 0;
      end else if (de) begin
         if (!m_half) begin
            m_lo = b; m_half = 1;
         end else begin
            m_half = 0;
            if (exp_q.size() >= DEPTH) m_ovf = 1;
            else begin
               exp_q.push_back({m_addr, b, m_lo});
               m_addr = m_addr + 1'b1;
            end
         end
      end
   endtask

   int ack_mode = 0;  // 0 = low, 1 = high, 2 = random (3 in 4)
   always @(posedge clk) begin
      #2;
      case (ack_mode)
         0:       wr_ack = 1'b0;
         1:       wr_ack = 1'b1;
         default: wr_ack = ($urandom_range(3) != 0);
      endcase
   end

   // compare process
   bit             prev_hold = 0;
   bit             prev_req  = 0;
   logic [AW+15:0] held;
   logic [AW+15:0] cmp_exp;
   int             req_rise_cyc = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 0;
         prev_req  = 0;
      end else begin
         if (prev_hold) begin
            check("hold_req", wr_req, 1);
            check("hold_bus", {wr_addr, wr_data}, held);
         end
         if (wr_req && !prev_req) req_rise_cyc = cyc;
         if (wr_req && wr_ack) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_write: got addr=0x%0h data=0x%0h, no write expected", wr_addr, wr_data);
            end else begin
               cmp_exp = exp_q.pop_front();
               check("write", {wr_addr, wr_data}, cmp_exp);
            end
            obs_log.push_back({wr_addr, wr_data});
         end
         prev_hold = wr_req && !wr_ack;
         held      = {wr_addr, wr_data};
         prev_req  = wr_req;
`ifndef AVR_FB_READBACK_EN
         check("doe_off", {avr_doe, avr_dout}, 9'h000);
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int we_rise_cyc = 0;
   task automatic avr_wr(input bit ae, input bit de, input logic [7:0] b);
      model_write(ae, de, b);
      avr_ae_p = ae; avr_de_p = de; avr_din = b; avr_we_n = 1'b0;
      tick(3);
      avr_we_n = 1'b1;
      we_rise_cyc = cyc;
      tick(4);
   endtask

   task automatic ce_toggle();
      m_aptr = 0; m_half = 0;
      avr_ce_n = 1'b1; tick(4);
      avr_ce_n = 1'b0; tick(4);
   endtask

   task automatic avr_rd();
      avr_ae_p = 1'b1; avr_de_p = 1'b0; avr_re_n = 1'b0; tick(4);
      avr_re_n = 1'b1; tick(2);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin tick(1); n++; end
      check(name, exp_q.size(), 0);
      tick(3);
   endtask

   logic [AW+15:0] w;
   int             base, n;

   initial begin
      rst = 1'b1; avr_din = 8'h00; avr_ce_n = 1'b0; avr_re_n = 1'b1; avr_we_n = 1'b1;
      avr_ae_p = 1'b0; avr_de_p = 1'b0; wr_ack = 1'b0;
      model_reset();
      tick(3);
      check("rst_req", wr_req, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
      check("rst_dout", avr_dout, 0);
      check("rst_doe", avr_doe, 0);
      check("rst_rdy", avr_r_n_b, 1);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick(2);

      // basic word, ack tied high
      ack_mode = 1;
      base = obs_log.size();
      avr_wr(1, 0, 8'h34); avr_wr(1, 0, 8'h12); avr_wr(1, 0, 8'h02);
      avr_wr(0, 1, 8'hCD); avr_wr(0, 1, 8'hAB);
      wait_drain("t1_drain");
      check("t1_count", obs_log.size() - base, 1);
      w = obs_log[base];
      check("t1_word", w, {18'h21234, 16'hABCD});
      check("t1_latency", req_rise_cyc - we_rise_cyc, 4);
      check("t1_model_addr", m_addr, 18'h21235);
      check("t1_req_idle", wr_req, 0);

      // address wrap
      ce_toggle();
      base = obs_log.size();
      avr_wr(1, 0, 8'hFF); avr_wr(1, 0, 8'hFF); avr_wr(1, 0, 8'h03);
      avr_wr(0, 1, 8'h01); avr_wr(0, 1, 8'h02); avr_wr(0, 1, 8'h03); avr_wr(0, 1, 8'h04);
      wait_drain("t2_drain");
      check("t2_count", obs_log.size() - base, 2);
      w = obs_log[base];     check("t2_word0", w, {18'h3FFFF, 16'h0201});
      w = obs_log[base + 1]; check("t2_word1", w, {18'h00000, 16'h0403});

      // overflow with ack held low
      ack_mode = 0;
      ce_toggle();
      avr_wr(1, 0, 8'h00); avr_wr(1, 0, 8'h01); avr_wr(1, 0, 8'h00);
      base = obs_log.size();
      for (int k = 0; k < 9; k++) begin
         avr_wr(0, 1, 8'(k)); avr_wr(0, 1, 8'(8'h50 + k));
         tick(2);
         check("t3_ready", avr_r_n_b, exp_q.size() < DEPTH - 1);
         check("t3_ovf", ovf, m_ovf);
      end
      check("t3_ovf_set", ovf, 1);
      check("t3_ready_low", avr_r_n_b, 0);
      ack_mode = 1;
      wait_drain("t3_drain");
      check("t3_count", obs_log.size() - base, 8);
      w = obs_log[base + 7]; check("t3_last", w, {18'h00107, 16'h5707});
      check("t3_ovf_sticky", ovf, 1);
      avr_wr(1, 0, 8'h00);
      tick(2);
      check("t3_ovf_clr", ovf, 0);
      check("t3_ready_hi", avr_r_n_b, 1);
      avr_wr(0, 1, 8'hE1); avr_wr(0, 1, 8'hE2);
      wait_drain("t3_after");
      w = obs_log[obs_log.size() - 1]; check("t3_next_addr", w, {18'h00108, 16'hE2E1});

      // late ack
      ack_mode = 0;
      base = obs_log.size();
      avr_wr(0, 1, 8'h77); avr_wr(0, 1, 8'h66);
      n = 0;
      while (!wr_req && n < 40) begin tick(1); n++; end
      check("t4_req_seen", wr_req, 1);
      tick(5);
      check("t4_req_held", wr_req, 1);
      check("t4_data_held", wr_data, 16'h6677);
      check("t4_no_pop", obs_log.size() - base, 0);
      ack_mode = 1;
      tick(1);
      ack_mode = 0;
      check("t4_req_drop", wr_req, 0);
      check("t4_popped", obs_log.size() - base, 1);
      tick(3);

      // lone byte discarded by ce_n deassertion
      ack_mode = 1;
      avr_wr(0, 1, 8'h11);
      ce_toggle();
      avr_wr(0, 1, 8'h22); avr_wr(0, 1, 8'h33);
      wait_drain("t5_drain");
      w = obs_log[obs_log.size() - 1]; check("t5_word", w[15:0], 16'h3322);

      // randomised traffic
      ack_mode = 2;
      ce_toggle();
      for (int i = 0; i < 80; i++) begin
         n = $urandom_range(99);
         if (n < 20)      avr_wr(1, 0, 8'($urandom_range(255)));
         else if (n < 75) avr_wr(0, 1, 8'($urandom_range(255)));
         else if (n < 85) ce_toggle();
         else if (n < 93) avr_wr(0, 0, 8'($urandom_range(255)));
         else             avr_rd();
      end
      ack_mode = 1;
      wait_drain("rnd_drain");
      check("rnd_ovf", ovf, m_ovf);
      check("rnd_ready", avr_r_n_b, 1);

      // reset mid-handshake
      ack_mode = 0;
      for (int k = 0; k < 3; k++) begin
         avr_wr(0, 1, 8'(k)); avr_wr(0, 1, 8'(8'hC0 + k));
      end
      tick(2);
      check("t6_req_before", wr_req, 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_req_async", wr_req, 0);
      check("t6_addr_clr", wr_addr, 0);
      tick(2);
      rst = 1'b0;
      ack_mode = 1;
      base = obs_log.size();
      tick(30);
      check("t6_no_writes", obs_log.size() - base, 0);
      check("t6_ready", avr_r_n_b, 1);
`ifdef AVR_FB_READBACK_EN
      avr_ae_p = 1'b1; avr_de_p = 1'b0; avr_re_n = 1'b0;
      tick(4);
      check("rb_doe", avr_doe, 1);
      check("rb_dout", avr_dout, 8'h20);
      avr_re_n = 1'b1;
      tick(4);
      check("rb_doe_off", avr_doe, 0);
`endif
      avr_wr(0, 1, 8'h5A); avr_wr(0, 1, 8'hA5);
      wait_drain("t6_new_data");
      w = obs_log[obs_log.size() - 1]; check("t6_new_word", w, {18'h00000, 16'hA55A});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
